alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's combinational ALU for the COD datapath. It accepts one operation per transaction on a valid/ready input port and returns a registered result with zero/carry/overflow flags on a valid/ready output port. Single-cycle logic and shift ops complete in 1 cycle. MUL completes in WIDTH cycles on an iterative shift-add multiplier. The block sits between instruction decode/operand fetch and write-back, and absorbs write-back stalls through output backpressure.

---
 rtl/alu_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and zero/carry/overflow flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 0C) and its BUSY state.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_NOR  = 5'h06;
    localparam logic [4:0] OP_SLT  = 5'h07;
    localparam logic [4:0] OP_SLTU = 5'h08;
    localparam logic [4:0] OP_SLL  = 5'h09;
    localparam logic [4:0] OP_SRL  = 5'h0A;
    localparam logic [4:0] OP_SRA  = 5'h0B;
    localparam logic [4:0] OP_MUL  = 5'h0C;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } alu_res_t;

    // Opcodes above MUL are reserved and behave exactly like NOP.
    function automatic logic op_is_nop(input logic [4:0] op);
        return (op == OP_NOP) || (op > OP_MUL);
    endfunction

    function automatic alu_res_t alu_eval(input logic [4:0] op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        alu_res_t                r;
        logic [WIDTH:0]          sum;
        logic [WIDTH:0]          diff;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHW-1:0]          amt;
        r    = '0;
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        sa   = a;
        sb   = b;
        amt  = b[SHW-1:0];
        case (op)
            OP_ADD: begin
                r.res = sum[WIDTH-1:0];
                r.c   = sum[WIDTH];
                r.v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The borrow out of the widened subtraction is exactly a < b unsigned.
                r.res = diff[WIDTH-1:0];
                r.c   = diff[WIDTH];
                r.v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  r.res = a & b;
            OP_OR:   r.res = a | b;
            OP_XOR:  r.res = a ^ b;
            OP_NOR:  r.res = ~(a | b);
            OP_SLT:  r.res = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: r.res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  r.res = a << amt;
            OP_SRL:  r.res = a >> amt;
            OP_SRA:  r.res = $unsigned(sa >>> amt);
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    alu_res_t         eval;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    assign in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign eval     = alu_eval(alu_op, alu_a, alu_b);

    always_comb begin
        state_d    = state_q;
        alu_out_d  = alu_out_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
`ifdef ALU_MUL_EN
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
`ifdef ALU_MUL_EN
            BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d    = DONE;
                    alu_out_d  = acc_step;
                    zero_d     = (acc_step == '0);
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                end
            end
`endif
            default: begin
                // DONE retires on out_ready; an accept in the same cycle overrides the return to IDLE.
                if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
                if (accept && !op_is_nop(alu_op)) begin
`ifdef ALU_MUL_EN
                    if (alu_op == OP_MUL) begin
                        state_d  = BUSY;
                        mcand_d  = alu_a;
                        mplier_d = alu_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else
`endif
                    begin
                        state_d    = DONE;
                        alu_out_d  = eval.res;
                        zero_d     = (eval.res == '0);
                        carry_d    = eval.c;
                        overflow_d = eval.v;
                    end
                end
            end
        endcase
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_out_q   <= '0;
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            alu_out_q   <= alu_out_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

`ifdef ALU_MUL_EN
    // Multiplier datapath is always reloaded on a MUL accept, so it carries no reset.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
    end
`endif

    assign alu_out   = alu_out_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH = 32; MUL expectations follow ALU_MUL_EN.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        zero;
    logic        carry;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        alu_a    = a;
        alu_b    = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] res,
                           input logic z, input logic c, input logic v);
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".out"},   alu_out,            res);
        chk({tag, ".zero"},  {31'b0, zero},      {31'b0, z});
        chk({tag, ".carry"}, {31'b0, carry},     {31'b0, c});
        chk({tag, ".ovf"},   {31'b0, overflow},  {31'b0, v});
    endtask

    logic [31:0] add_a [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0010};
    logic [31:0] add_b [4] = '{32'h0000_0002, 32'h0000_0001, 32'h8000_0000, 32'h0000_0020};
    logic [31:0] add_r [4] = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 32'h0000_0030};
    logic        add_z [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        add_c [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        add_v [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 5'h00;
        alu_a     = '0;
        alu_b     = '0;

        // Reset state
        tick();
        tick();
        chk("rst.valid", {31'b0, out_valid}, 32'd0);
        chk("rst.out",   alu_out,            32'd0);
        chk("rst.zero",  {31'b0, zero},      32'd1);
        chk("rst.carry", {31'b0, carry},     32'd0);
        chk("rst.ovf",   {31'b0, overflow},  32'd0);
        chk("rst.ready", {31'b0, in_ready},  32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle.ready", {31'b0, in_ready}, 32'd1);

        // Single-cycle ops, back to back with out_ready high
        issue(5'h01, 32'h7FFF_FFFF, 32'h0000_0001);
        chk_res("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        issue(5'h02, 32'h0000_0001, 32'h0000_0002);
        chk_res("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        issue(5'h07, 32'hFFFF_FFFF, 32'h0000_0001);
        chk_res("slt", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        issue(5'h08, 32'hFFFF_FFFF, 32'h0000_0001);
        chk_res("sltu", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        issue(5'h0B, 32'h8000_0000, 32'h0000_0024);
        chk_res("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        issue(5'h09, 32'h0000_0001, 32'd31);
        chk_res("sll", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        issue(5'h06, 32'h0F0F_0000, 32'h00F0_FFFF);
        chk_res("nor", 32'hF000_0000, 1'b0, 1'b0, 1'b0);

        // MUL
        issue(5'h0C, 32'h0000_FFFF, 32'h0001_0001);
`ifdef ALU_MUL_EN
        for (int i = 0; i < 32; i++) begin
            chk("mul.busy_ready", {31'b0, in_ready},  32'd0);
            chk("mul.busy_valid", {31'b0, out_valid}, 32'd0);
            tick();
        end
        chk_res("mul", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
`else
        chk_res("mul_off", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
`endif

        // Backpressure: AND result held while an XOR waits
        issue(5'h03, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 5'h05;
        alu_a     = 32'hFFFF_0000;
        alu_b     = 32'h0F0F_0F0F;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk_res("and_hold", 32'h00F0_000F, 1'b0, 1'b0, 1'b0);
            chk("hold.ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release.ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk_res("xor", 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0);

        // Throughput: four back-to-back ADDs
        for (int i = 0; i < 4; i++) begin
            alu_op = 5'h01;
            alu_a  = add_a[i];
            alu_b  = add_b[i];
            tick();
            chk_res("add_stream", add_r[i], add_z[i], add_c[i], add_v[i]);
        end
        in_valid = 1'b0;
        tick();
        chk("stream.drain", {31'b0, out_valid}, 32'd0);

`ifdef ALU_MUL_EN
        // Reset during BUSY aborts the MUL
        issue(5'h0C, 32'd5, 32'd7);
        repeat (9) tick();
        chk("mulrst.busy", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mulrst.valid", {31'b0, out_valid}, 32'd0);
        chk("mulrst.out",   alu_out,            32'd0);
        chk("mulrst.ready", {31'b0, in_ready},  32'd1);
        seen_valid = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("mulrst.no_output", {31'b0, seen_valid}, 32'd0);
`endif

        // Reset while a result is pending in DONE
        out_ready = 1'b0;
        issue(5'h01, 32'd3, 32'd4);
        chk_res("pend", 32'd7, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("donerst.ready_low", {31'b0, in_ready}, 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("donerst.valid", {31'b0, out_valid}, 32'd0);
        chk("donerst.out",   alu_out,            32'd0);
        chk("donerst.zero",  {31'b0, zero},      32'd1);

        // NOP and reserved opcodes are accepted but produce nothing
        chk("nop.ready", {31'b0, in_ready}, 32'd1);
        issue(5'h00, 32'd5, 32'd5);
        chk("nop.valid",     {31'b0, out_valid}, 32'd0);
        chk("nop.out",       alu_out,            32'd0);
        chk("nop.ready_aft", {31'b0, in_ready},  32'd1);
        issue(5'h1F, 32'd9, 32'd9);
        chk("rsvd.valid", {31'b0, out_valid}, 32'd0);
        chk("rsvd.out",   alu_out,            32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
